// File: rtl/axis_n_way_adder.sv
// N-channel stream adder: one FIFO per input channel, a join that sums the N heads
// (wrap or saturate), and an output FIFO carrying {overflow, result}.
module axis_n_way_adder #(
    parameter int width    = 4,
    parameter int depth    = 4,
    parameter int n_inputs = 3,
    parameter int saturate = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [n_inputs-1:0]       in_valid,
    output logic [n_inputs-1:0]       in_ready,
    input  logic [n_inputs*width-1:0] in_data,
    output logic                      sum_valid,
    input  logic                      sum_ready,
    output logic [width-1:0]          sum_data,
    output logic                      sum_sat
);

    localparam int aw = $clog2(depth);
    localparam int sw = width + $clog2(n_inputs);
    localparam logic [aw:0] ptr_one = 1;

    logic [n_inputs-1:0] in_empty;
    logic [width-1:0]    head [n_inputs];
    logic                fire;
    logic                out_full;

    for (genvar i = 0; i < n_inputs; i++) begin : g_in
        logic [width-1:0] mem [depth];
        logic [aw:0]      wr_ptr;
        logic [aw:0]      rd_ptr;
        logic             full;
        logic             push;

        // Extra pointer MSB distinguishes full from empty when the index bits match.
        assign full        = (wr_ptr[aw] != rd_ptr[aw]) && (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]);
        assign in_empty[i] = (wr_ptr == rd_ptr);
        assign in_ready[i] = ~full;
        assign push        = in_valid[i] & ~full;
        assign head[i]     = mem[rd_ptr[aw-1:0]];

        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + ptr_one;
                if (fire) rd_ptr <= rd_ptr + ptr_one;
            end
        end

        // NOTE: storage arrays are not reset; the pointers alone define which entries are valid.
        always_ff @(posedge clk) begin
            if (push) mem[wr_ptr[aw-1:0]] <= in_data[i*width +: width];
        end
    end

    logic [sw-1:0]    full_sum;
    logic             ovf;
    logic [width-1:0] result;

    // NOTE: combinational blocks use blocking assignments and give every output a default
    // first, so the accumulation reads the value just written and no latch is inferred.
    always_comb begin
        full_sum = '0;
        for (int i = 0; i < n_inputs; i++) begin
            full_sum = full_sum + sw'(head[i]);
        end
        ovf    = |full_sum[sw-1:width];
        result = full_sum[width-1:0];
        if (saturate != 0 && ovf) result = '1;
    end

    assign fire = ~|in_empty & ~out_full;

    logic [width:0] out_mem [depth];
    logic [aw:0]    out_wr_ptr;
    logic [aw:0]    out_rd_ptr;
    logic           out_pop;

    assign out_full  = (out_wr_ptr[aw] != out_rd_ptr[aw]) &&
                       (out_wr_ptr[aw-1:0] == out_rd_ptr[aw-1:0]);
    assign sum_valid = (out_wr_ptr != out_rd_ptr);
    assign out_pop   = sum_valid & sum_ready;
    assign {sum_sat, sum_data} = out_mem[out_rd_ptr[aw-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            out_wr_ptr <= '0;
            out_rd_ptr <= '0;
        end else begin
            if (fire)    out_wr_ptr <= out_wr_ptr + ptr_one;
            if (out_pop) out_rd_ptr <= out_rd_ptr + ptr_one;
        end
    end

    always_ff @(posedge clk) begin
        if (fire) out_mem[out_wr_ptr[aw-1:0]] <= {ovf, result};
    end

endmodule
